nvme_sync_filter: RTL and testbench



---
 rtl/nvme_sync_filter_if.sv | 37 +++
 rtl/nvme_sync_filter.sv | 144 ++++++++++++++
 tb/tb_nvme_sync_filter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvme_sync_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : nvme_sync_filter_if
// Purpose  : Event delivery handshake between the status filter and the
//            NVMe control logic. One event = (bit index, new level).
// Signals  : evt_valid  - producer holds an event
//            evt_ready  - consumer accepts the event this cycle
//            evt_idx    - status bit index of the event (IW bits)
//            evt_level  - new filtered level of that bit
// Modports : master (event producer), slave (event consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface nvme_sync_filter_if #(
  parameter int IW = 2
);

  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_idx;
  logic          evt_level;

  modport master (
    output evt_valid,
    output evt_idx,
    output evt_level,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_idx,
    input  evt_level,
    output evt_ready
  );

endinterface
`default_nettype wire

// File: rtl/nvme_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : nvme_sync_filter
// Purpose  : Debounces a bundle of already-synchronized slow status bits
//            (PERST, link-up, power-good, ...). A bit must hold a new value
//            for FILTER consecutive cycles before it is accepted. Each
//            accepted change produces a one-cycle rise/fall pulse and an
//            event delivered over a valid/ready handshake.
// Ports    : clk       - sole clock
//            reset_n   - asynchronous active-low reset
//            d_sync    - synchronizer outputs, WIDTH bits, clk domain
//            q         - filtered levels
//            rise/fall - one-cycle pulses on accepted 0->1 / 1->0 changes
//            evt       - event handshake (master side)
//            ovfl      - sticky: an undelivered event on this bit was
//                        overwritten by a newer one
//            ovfl_clr  - per-bit clear for ovfl (a coincident set wins)
// Revision : 1.0 - initial release
// ============================================================================
module nvme_sync_filter #(
  parameter int               WIDTH     = 4,
  parameter int               FILTER    = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire              clk,
  input  wire              reset_n,
  input  wire [WIDTH-1:0]  d_sync,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  nvme_sync_filter_if.master evt,
  output logic [WIDTH-1:0] ovfl,
  input  wire [WIDTH-1:0]  ovfl_clr
);

  localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int             CW       = $clog2(FILTER + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

  // --------------------------------------------------------------------------
  // Per-bit filter state
  // --------------------------------------------------------------------------
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] toggle;      // q[i] flips at the coming edge

  // --------------------------------------------------------------------------
  // Pending events (one slot per bit) and the output event register
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pend_lvl;
  logic [WIDTH-1:0] sel_oh;      // lowest-index pending bit, one-hot
  logic [WIDTH-1:0] take;        // pending bit being moved to the output
  logic [IW-1:0]    sel_idx;
  logic             load;

  logic             ev_valid;
  logic [IW-1:0]    ev_idx;
  logic             ev_level;

  // A change is accepted on the FILTER-th consecutive differing sample.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = (d_sync[i] != q[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // Pulses are registered alongside q so they line up with the new level.
      rise <= toggle & ~q;
      fall <= toggle &  q;
      q    <= q ^ toggle;
      for (int i = 0; i < WIDTH; i++) begin
        // Any cycle of agreement restarts the count; an accepted change
        // also restarts it so the next change needs a full FILTER window.
        if ((d_sync[i] == q[i]) || toggle[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Lowest set bit: x & -x.
  always_comb begin
    sel_oh  = pending & (~pending + WIDTH'(1));
    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = IW'(i);
      end
    end
  end

  // The output register is free when empty or being accepted this edge.
  // Only registered state feeds the outputs, so evt_ready never reaches an
  // output combinationally.
  assign load = (!ev_valid || evt.evt_ready) && (|pending);
  assign take = load ? sel_oh : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      pend_lvl <= '0;
      ovfl     <= '0;
    end else begin
      // A change arriving on the edge its slot is emptied simply refills it;
      // only a change landing on a still-occupied slot counts as overflow.
      pending  <= toggle | (pending & ~take);
      pend_lvl <= (pend_lvl & ~toggle) | (~q & toggle);
      ovfl     <= (ovfl & ~ovfl_clr) | (toggle & pending & ~take);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid <= 1'b0;
      ev_idx   <= '0;
      ev_level <= 1'b0;
    end else if (load) begin
      ev_valid <= 1'b1;
      ev_idx   <= sel_idx;
      ev_level <= |(pend_lvl & sel_oh);
    end else if (evt.evt_ready) begin
      // Accepted with nothing waiting behind it; idx/level keep their value.
      ev_valid <= 1'b0;
    end
  end

  assign evt.evt_valid = ev_valid;
  assign evt.evt_idx   = ev_idx;
  assign evt.evt_level = ev_level;

endmodule
`default_nettype wire

// File: tb/tb_nvme_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvme_sync_filter
// Purpose  : Self-checking bench for nvme_sync_filter.
//            dut_a : WIDTH=4, FILTER=16, RESET_VAL=0000 - directed sequences
//            dut_b : WIDTH=4, FILTER=3,  RESET_VAL=0101 - reset hold, random
//                    stimulus against a reference model
//            dut_c : WIDTH=4, FILTER=1,  RESET_VAL=0000 - vector table
// Revision : 1.0 - initial release
// ============================================================================
module tb_nvme_sync_filter;

  localparam int FB = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] d_a, d_b, d_c;
  logic [3:0] q_a, q_b, q_c;
  logic [3:0] rise_a, rise_b, rise_c;
  logic [3:0] fall_a, fall_b, fall_c;
  logic [3:0] ovfl_a, ovfl_b, ovfl_c;
  logic [3:0] clr_a, clr_b, clr_c;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nvme_sync_filter_if #(.IW(2)) ev_a ();
  nvme_sync_filter_if #(.IW(2)) ev_b ();
  nvme_sync_filter_if #(.IW(2)) ev_c ();

  nvme_sync_filter #(.WIDTH(4), .FILTER(16), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .reset_n(reset_n), .d_sync(d_a), .q(q_a), .rise(rise_a),
    .fall(fall_a), .evt(ev_a), .ovfl(ovfl_a), .ovfl_clr(clr_a));

  nvme_sync_filter #(.WIDTH(4), .FILTER(FB), .RESET_VAL(4'b0101)) dut_b (
    .clk(clk), .reset_n(reset_n), .d_sync(d_b), .q(q_b), .rise(rise_b),
    .fall(fall_b), .evt(ev_b), .ovfl(ovfl_b), .ovfl_clr(clr_b));

  nvme_sync_filter #(.WIDTH(4), .FILTER(1), .RESET_VAL(4'b0000)) dut_c (
    .clk(clk), .reset_n(reset_n), .d_sync(d_c), .q(q_c), .rise(rise_c),
    .fall(fall_c), .evt(ev_c), .ovfl(ovfl_c), .ovfl_clr(clr_c));

  // --------------------------------------------------------------------------
  // Vector table for the FILTER=1 instance
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] d;
    logic       ready;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       valid;
    logic [1:0] idx;
    logic       level;
  } vec_t;

  vec_t tbl [10];

  // --------------------------------------------------------------------------
  // Reference model state for dut_b
  // --------------------------------------------------------------------------
  logic [3:0] hist [$];     // last FB samples of d_b
  logic [3:0] mq, mrise, mfall, mpend, mpl, movfl;
  logic       mv, mlvl;
  logic [1:0] midx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One model step using the inputs about to be sampled at the next edge.
  task automatic model_step(input logic [3:0] d, input logic rdy, input logic [3:0] clr);
    logic [3:0] tog, tk;
    logic       ld, all_diff;
    int         sel;
    hist.push_back(d);
    if (hist.size() > FB) void'(hist.pop_front());
    tog = '0;
    if (hist.size() == FB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][i] == mq[i]) all_diff = 1'b0;
        tog[i] = all_diff;
      end
    end
    sel = 0;
    for (int i = 3; i >= 0; i--) if (mpend[i]) sel = i;
    ld = (!mv || rdy) && (mpend != 0);
    tk = ld ? (4'b0001 << sel) : 4'b0000;
    if (ld) begin
      mv   = 1'b1;
      midx = 2'(sel);
      mlvl = mpl[sel];
    end else if (rdy) begin
      mv = 1'b0;
    end
    movfl = (movfl & ~clr) | (tog & mpend & ~tk);
    mpend = tog | (mpend & ~tk);
    for (int i = 0; i < 4; i++) if (tog[i]) mpl[i] = ~mq[i];
    mrise = tog & ~mq;
    mfall = tog & mq;
    mq    = mq ^ tog;
  endtask

  initial begin
    reset_n = 1'b0;
    d_a = 4'b0000; d_b = 4'b0101; d_c = 4'b0000;
    clr_a = '0; clr_b = '0; clr_c = '0;
    ev_a.evt_ready = 1'b1; ev_b.evt_ready = 1'b1; ev_c.evt_ready = 1'b1;

    //              d     rdy   q      rise   fall  v  idx  lvl
    tbl[0] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[3] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[5] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[9] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // ---------------- reset state ----------------
    chk("reset_a", {q_a, rise_a, fall_a, ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level, ovfl_a}, 32'h0);
    repeat (100) begin
      tick();
      chk("reset_hold_b", {q_b, rise_b, fall_b, ev_b.evt_valid, ovfl_b},
          {4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000});
    end

    // ---------------- FILTER=1 table ----------------
    for (int v = 0; v < 10; v++) begin
      d_c = tbl[v].d;
      ev_c.evt_ready = tbl[v].ready;
      tick();
      chk($sformatf("f1_vec%0d", v),
          {q_c, rise_c, fall_c, ev_c.evt_valid, ev_c.evt_idx, ev_c.evt_level, ovfl_c},
          {tbl[v].q, tbl[v].rise, tbl[v].fall, tbl[v].valid, tbl[v].idx, tbl[v].level, 4'b0000});
    end

    // ---------------- FILTER=16 glitch and acceptance ----------------
    d_a[2] = 1'b1;
    repeat (15) begin
      tick();
      chk("glitch15_q_rise", {q_a, rise_a}, 8'h00);
    end
    d_a[2] = 1'b0;
    repeat (4) tick();
    chk("glitch15_after", {q_a, ev_a.evt_valid}, 5'h00);
    d_a[2] = 1'b1;
    repeat (15) tick();
    chk("hold15_q", q_a, 4'b0000);
    tick();
    chk("hold16_q_rise", {q_a, rise_a, ev_a.evt_valid}, {4'b0100, 4'b0100, 1'b0});
    tick();
    chk("hold16_evt", {rise_a, ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level},
        {4'b0000, 1'b1, 2'd2, 1'b1});
    tick();
    chk("hold16_drain", ev_a.evt_valid, 1'b0);

    // ---------------- simultaneous changes, stalled consumer ----------------
    ev_a.evt_ready = 1'b0;
    d_a = 4'b1110;
    repeat (16) tick();
    chk("dual_q_rise", {q_a, rise_a}, {4'b1110, 4'b1010});
    tick();
    chk("dual_first", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level}, {1'b1, 2'd1, 1'b1});
    repeat (5) begin
      tick();
      chk("dual_stall", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level}, {1'b1, 2'd1, 1'b1});
    end
    ev_a.evt_ready = 1'b1;
    tick();
    chk("dual_second", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level}, {1'b1, 2'd3, 1'b1});
    tick();
    chk("dual_drain", ev_a.evt_valid, 1'b0);

    // ---------------- overflow ----------------
    d_a[0] = 1'b1;
    repeat (18) tick();
    chk("ovf_prep", {q_a, ev_a.evt_valid, ovfl_a}, {4'b1111, 1'b0, 4'b0000});
    ev_a.evt_ready = 1'b0;
    d_a[0] = 1'b0;
    repeat (16) tick();
    chk("ovf_fall", {q_a, fall_a}, {4'b1110, 4'b0001});
    tick();
    chk("ovf_reg", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level}, {1'b1, 2'd0, 1'b0});
    d_a[0] = 1'b1;
    repeat (16) tick();
    chk("ovf_pend_no_ovfl", {q_a, ovfl_a}, {4'b1111, 4'b0000});
    d_a[0] = 1'b0;
    repeat (16) tick();
    chk("ovf_set", {ovfl_a, ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level},
        {4'b0001, 1'b1, 2'd0, 1'b0});
    ev_a.evt_ready = 1'b1;
    tick();
    ev_a.evt_ready = 1'b0;
    chk("ovf_pend_lvl", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level, ovfl_a},
        {1'b1, 2'd0, 1'b0, 4'b0001});
    d_a[0] = 1'b1;
    repeat (16) tick();
    chk("ovf_sticky", ovfl_a, 4'b0001);
    clr_a = 4'b0001;
    tick();
    clr_a = 4'b0000;
    chk("ovf_clr", ovfl_a, 4'b0000);
    d_a[0] = 1'b0;
    repeat (15) tick();
    clr_a = 4'b0001;
    tick();
    chk("ovf_set_wins", ovfl_a, 4'b0001);
    tick();
    clr_a = 4'b0000;
    chk("ovf_clr2", ovfl_a, 4'b0000);
    ev_a.evt_ready = 1'b1;
    tick();
    chk("ovf_deliver", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level}, {1'b1, 2'd0, 1'b0});
    tick();
    chk("ovf_empty", ev_a.evt_valid, 1'b0);

    // ---------------- asynchronous reset mid-count with event held ----------------
    ev_a.evt_ready = 1'b0;
    d_a[3] = 1'b0;
    repeat (17) tick();
    chk("rst_pre_evt", {ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level}, {1'b1, 2'd3, 1'b0});
    d_a[1] = 1'b0;
    repeat (8) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", {q_a, rise_a, fall_a, ev_a.evt_valid, ev_a.evt_idx, ev_a.evt_level, ovfl_a}, 32'h0);
    #1 reset_n = 1'b1;
    repeat (15) tick();
    chk("rst_restart15", q_a, 4'b0000);
    tick();
    chk("rst_restart16", {q_a, rise_a}, {4'b0100, 4'b0100});

    // ---------------- random stimulus against the model (dut_b) ----------------
    mq = 4'b0101; mrise = '0; mfall = '0; mpend = '0; mpl = '0; movfl = '0;
    mv = 1'b0; midx = '0; mlvl = 1'b0;
    hist.delete();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) d_b[i] = ~d_b[i];
        clr_b[i] = ($urandom_range(0, 15) == 0);
      end
      ev_b.evt_ready = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      model_step(d_b, ev_b.evt_ready, clr_b);
      tick();
      chk("random_b",
          {q_b, rise_b, fall_b, ev_b.evt_valid, ev_b.evt_idx, ev_b.evt_level, ovfl_b},
          {mq, mrise, mfall, mv, midx, mlvl, movfl});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
